// File: rtl/kpc_note_pkg.sv
// Shared types and constants for the keyboard note path: note width, reset note,
// scheduler FSM states and the stack-count width helper.
package kpc_note_pkg;

  localparam int unsigned NOTE_W = 7;
  localparam logic [NOTE_W-1:0] DEFAULT_NOTE_C = 7'd48;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_COMPACT = 3'd2,
    ST_PUSH    = 3'd3,
    ST_UPDATE  = 3'd4
  } state_t;

  // Bits needed to hold a count of 0..depth entries.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/note_priority_scheduler_note_stack.sv
// Held-note register array: indexed read, shift-down from an index, write at an index.
module note_stack
  import kpc_note_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                      a_clk,
  input  logic                      reset,
  input  logic [$clog2(DEPTH)-1:0]  rd_idx,
  output logic [NOTE_W-1:0]         rd_note,
  input  logic                      shift_en,
  input  logic [$clog2(DEPTH)-1:0]  shift_idx,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_idx,
  input  logic [NOTE_W-1:0]         wr_note
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [NOTE_W-1:0] mem [DEPTH];

  // Mux-style read keeps non-power-of-two depths in range.
  always_comb begin
    rd_note = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (rd_idx == IW'(i)) rd_note = mem[i];
    end
  end

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (shift_en && (shift_idx == IW'(i))) mem[i] <= mem[i+1];
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wr_en && (wr_idx == IW'(i))) mem[i] <= wr_note;
      end
    end
  end

endmodule

// File: rtl/note_priority_scheduler.sv
// Last-note-priority scheduler: keeps an ordered stack of held notes and drives
// note_out/gate/retrig to the pitch datapath and envelope logic.
module note_priority_scheduler
  import kpc_note_pkg::*;
#(
  parameter int unsigned       DEPTH        = 8,
  parameter logic [NOTE_W-1:0] DEFAULT_NOTE = DEFAULT_NOTE_C
) (
  input  logic                         a_clk,
  input  logic                         reset,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic                         legato,
  input  logic                         panic,
  output logic [NOTE_W-1:0]            note_out,
  output logic                         gate,
  output logic                         retrig,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   stack_count
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned IW = $clog2(DEPTH);

  state_t            state, state_nx;
  logic [CW-1:0]     idx, m;
  logic              found, ovf_flag;
  logic              ev_on_q;
  logic [NOTE_W-1:0] ev_note_q;

  logic [IW-1:0]     rd_idx, top_idx;
  logic [NOTE_W-1:0] rd_note;
  logic              shift_en, wr_en;
  logic              hit, last_scan, match_any, ovf_cond, remove, skip_compact, last_shift;
  logic [CW-1:0]     m_sel;

  note_stack #(.DEPTH(DEPTH)) u_stack (
    .a_clk     (a_clk),
    .reset     (reset),
    .rd_idx    (rd_idx),
    .rd_note   (rd_note),
    .shift_en  (shift_en),
    .shift_idx (IW'(idx)),
    .wr_en     (wr_en),
    .wr_idx    (IW'(stack_count)),
    .wr_note   (ev_note_q)
  );

  assign ev_ready     = (state == ST_IDLE);
  assign top_idx      = (stack_count == '0) ? '0 : IW'(stack_count - CW'(1));
  assign rd_idx       = (state == ST_UPDATE) ? top_idx : IW'(idx);
  assign hit          = (rd_note == ev_note_q);
  assign last_scan    = (idx == stack_count - CW'(1));
  assign match_any    = found || hit;
  assign ovf_cond     = !match_any && ev_on_q && (stack_count == CW'(DEPTH));
  assign remove       = match_any || ovf_cond;
  assign m_sel        = hit ? idx : (found ? m : '0);
  // Removing the top entry needs no shifting, so COMPACT is bypassed.
  assign skip_compact = (m_sel == stack_count - CW'(1));
  assign last_shift   = (idx == stack_count - CW'(2));

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    wr_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!panic && ev_valid) state_nx = (stack_count == '0) ? ST_PUSH : ST_SCAN;
      end
      ST_SCAN: begin
        if (last_scan) begin
          if (remove && !skip_compact) state_nx = ST_COMPACT;
          else                         state_nx = ev_on_q ? ST_PUSH : ST_UPDATE;
        end
      end
      ST_COMPACT: begin
        shift_en = 1'b1;
        if (last_shift) state_nx = ev_on_q ? ST_PUSH : ST_UPDATE;
      end
      ST_PUSH: begin
        wr_en    = 1'b1;
        state_nx = ST_UPDATE;
      end
      ST_UPDATE: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      m           <= '0;
      found       <= 1'b0;
      ovf_flag    <= 1'b0;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      stack_count <= '0;
      note_out    <= DEFAULT_NOTE;
      gate        <= 1'b0;
      retrig      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      retrig   <= 1'b0;
      overflow <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (panic) begin
            stack_count <= '0;
            gate        <= 1'b0;
          end else if (ev_valid) begin
            ev_on_q   <= ev_on;
            ev_note_q <= ev_note;
            idx       <= '0;
            m         <= '0;
            found     <= 1'b0;
            ovf_flag  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (hit) begin
            found <= 1'b1;
            m     <= idx;
          end
          idx <= idx + CW'(1);
          if (last_scan) begin
            ovf_flag <= ovf_cond;
            if (remove) begin
              idx <= m_sel;
              if (skip_compact) stack_count <= stack_count - CW'(1);
            end
          end
        end
        ST_COMPACT: begin
          idx <= idx + CW'(1);
          if (last_shift) stack_count <= stack_count - CW'(1);
        end
        ST_PUSH: stack_count <= stack_count + CW'(1);
        ST_UPDATE: begin
          gate <= (stack_count != '0);
          if (stack_count != '0) note_out <= rd_note;
          retrig   <= ev_on_q && (!legato || !gate);
          overflow <= ovf_flag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_priority_scheduler.sv
// Bench for note_priority_scheduler: queue-based reference model checked every
// cycle, plus hand-computed latencies and output values for directed events.
module tb_note_priority_scheduler;

  localparam int unsigned DEPTH = 8;

  logic       a_clk = 1'b0;
  logic       reset = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_ready;
  logic       ev_on = 1'b0;
  logic [6:0] ev_note = 7'd0;
  logic       legato = 1'b0;
  logic       panic = 1'b0;
  logic [6:0] note_out;
  logic       gate, retrig, overflow;
  logic [$clog2(DEPTH+1)-1:0] stack_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  note_priority_scheduler #(.DEPTH(DEPTH), .DEFAULT_NOTE(7'd48)) dut (
    .a_clk       (a_clk),
    .reset       (reset),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_on       (ev_on),
    .ev_note     (ev_note),
    .legato      (legato),
    .panic       (panic),
    .note_out    (note_out),
    .gate        (gate),
    .retrig      (retrig),
    .overflow    (overflow),
    .stack_count (stack_count)
  );

  always #5 a_clk = ~a_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: held notes as a queue, outputs applied after the event latency.
  logic [6:0] q[$];
  logic [6:0] m_note = 7'd48;
  bit         m_gate = 0, m_retrig = 0, m_ovf = 0, m_ready = 1;
  int         m_count = 0, pend = 0;
  logic [6:0] p_note;
  bit         p_gate, p_retrig, p_ovf;
  int         hit_at, n_held, n_compact, n_push;

  always @(posedge a_clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_note = 7'd48; m_gate = 0; m_retrig = 0; m_ovf = 0; m_ready = 1;
      m_count = 0; pend = 0;
    end else begin
      m_retrig = 0;
      m_ovf    = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_note = p_note; m_gate = p_gate; m_retrig = p_retrig; m_ovf = p_ovf; m_ready = 1;
        end
      end else if (panic) begin
        q.delete();
        m_gate  = 0;
        m_count = 0;
      end else if (ev_valid) begin
        n_held = q.size();
        hit_at = -1;
        for (int i = 0; i < q.size(); i++) if (q[i] == ev_note) hit_at = i;
        n_compact = 0;
        p_ovf     = 0;
        if (hit_at >= 0) begin
          n_compact = n_held - 1 - hit_at;
          q.delete(hit_at);
        end else if (ev_on && n_held == int'(DEPTH)) begin
          n_compact = n_held - 1;
          q.delete(0);
          p_ovf = 1;
        end
        n_push = 0;
        if (ev_on) begin
          q.push_back(ev_note);
          n_push = 1;
        end
        p_gate   = (q.size() != 0);
        p_note   = (q.size() != 0) ? q[q.size()-1] : m_note;
        p_retrig = ev_on && (!legato || !m_gate);
        m_count  = q.size();
        pend     = n_held + n_compact + n_push + 1;
        m_ready  = 0;
      end
    end
  end

  always @(negedge a_clk) begin
    if (chk_on) begin
      chk("cyc_note_out", 32'(note_out), 32'(m_note));
      chk("cyc_gate", 32'(gate), 32'(m_gate));
      chk("cyc_retrig", 32'(retrig), 32'(m_retrig));
      chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
      chk("cyc_ev_ready", 32'(ev_ready), 32'(m_ready));
      if (m_ready) chk("cyc_stack_count", 32'(stack_count), 32'(m_count));
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ev_ready && n < 200) begin
      @(negedge a_clk);
      n++;
    end
    if (!ev_ready) chk({name, "_ready_timeout"}, 32'(ev_ready), 32'd1);
  endtask

  // Issue one event; lat = edges from the accepting edge until ready returns.
  task automatic send(input logic on, input logic [6:0] note, output int lat);
    wait_ready("send");
    ev_valid = 1'b1; ev_on = on; ev_note = note;
    @(negedge a_clk);
    ev_valid = 1'b0; ev_on = 1'($urandom); ev_note = 7'($urandom);
    lat = 0;
    while (!ev_ready && lat < 200) begin
      @(negedge a_clk);
      lat++;
    end
  endtask

  task automatic expect_out(input string name, input int lat, input int e_lat,
                            input int e_note, input int e_gate, input int e_retrig,
                            input int e_ovf, input int e_cnt);
    chk({name, "_lat"}, 32'(lat), 32'(e_lat));
    chk({name, "_note"}, 32'(note_out), 32'(e_note));
    chk({name, "_gate"}, 32'(gate), 32'(e_gate));
    chk({name, "_retrig"}, 32'(retrig), 32'(e_retrig));
    chk({name, "_ovf"}, 32'(overflow), 32'(e_ovf));
    chk({name, "_cnt"}, 32'(stack_count), 32'(e_cnt));
  endtask

  task automatic do_panic(input string name, input int e_note);
    wait_ready(name);
    panic = 1'b1;
    @(negedge a_clk);
    panic = 1'b0;
    chk({name, "_gate"}, 32'(gate), 32'd0);
    chk({name, "_note"}, 32'(note_out), 32'(e_note));
    chk({name, "_cnt"}, 32'(stack_count), 32'd0);
  endtask

  initial begin
    int lat;
    #2 reset = 1'b1;
    #1 chk_on = 1'b1;
    repeat (2) @(negedge a_clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge a_clk);
    expect_out("reset", 0, 0, 48, 0, 0, 0, 0);
    chk("reset_ready", 32'(ev_ready), 32'd1);

    // Legato: retrig only when the gate rises.
    legato = 1'b1;
    send(1, 60, lat); expect_out("leg_on60", lat, 2, 60, 1, 1, 0, 1);
    send(1, 64, lat); expect_out("leg_on64", lat, 3, 64, 1, 0, 0, 2);
    send(0, 64, lat); expect_out("leg_off64", lat, 3, 60, 1, 0, 0, 1);
    send(0, 60, lat); expect_out("leg_off60", lat, 2, 60, 0, 0, 0, 0);

    // Non-legato: retrig on every note-on.
    legato = 1'b0;
    send(1, 60, lat); expect_out("nl_on60", lat, 2, 60, 1, 1, 0, 1);
    send(1, 64, lat); expect_out("nl_on64", lat, 3, 64, 1, 1, 0, 2);
    send(0, 64, lat);
    send(0, 60, lat); expect_out("nl_empty", lat, 2, 60, 0, 0, 0, 0);

    // Fill the stack, then overflow drops the oldest note.
    for (int n = 60; n < 68; n++) send(1, 7'(n), lat);
    expect_out("fill", lat, 9, 67, 1, 1, 0, 8);
    send(1, 68, lat); expect_out("ovf_on68", lat, 17, 68, 1, 1, 1, 8);
    @(negedge a_clk);
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
    send(0, 61, lat); expect_out("off61", lat, 16, 68, 1, 0, 0, 7);
    do_panic("panic7", 68);

    // Re-pressing a held note moves it to the top; unheld note-off is ignored.
    send(1, 60, lat);
    send(1, 62, lat);
    send(1, 60, lat); expect_out("retop60", lat, 5, 60, 1, 1, 0, 2);
    send(0, 70, lat); expect_out("off70", lat, 3, 60, 1, 0, 0, 2);
    send(1, 65, lat); expect_out("on65", lat, 4, 65, 1, 1, 0, 3);
    send(1, 67, lat); expect_out("on67_cnt3", lat, 5, 67, 1, 1, 0, 4);
    send(1, 67, lat); expect_out("on67_top", lat, 6, 67, 1, 1, 0, 4);
    send(1, 69, lat); expect_out("on69", lat, 6, 69, 1, 1, 0, 5);

    // Reset while scanning a 5-deep stack.
    wait_ready("rst_scan");
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd71;
    @(negedge a_clk);
    ev_valid = 1'b0;
    @(negedge a_clk);
    chk("in_scan_ready", 32'(ev_ready), 32'd0);
    #1 reset = 1'b1;
    #1 expect_out("rst_mid", 0, 0, 48, 0, 0, 0, 0);
    chk("rst_mid_ready", 32'(ev_ready), 32'd1);
    @(negedge a_clk);
    #1 reset = 1'b0;
    @(negedge a_clk);
    send(1, 50, lat); expect_out("post_rst_on50", lat, 2, 50, 1, 1, 0, 1);

    // Panic with three held notes holds note_out.
    send(1, 52, lat); expect_out("on52", lat, 3, 52, 1, 1, 0, 2);
    send(1, 55, lat); expect_out("on55", lat, 4, 55, 1, 1, 0, 3);
    do_panic("panic3", 55);
    repeat (3) @(negedge a_clk);
    chk("idle_after_panic_gate", 32'(gate), 32'd0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
